rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters; the winner's 3-bit index is expanded to a one-hot grant vector.
- Sits in front of shared NPC resources such as the LED/segment bus or a debug port.
- Adds sequencing on top of plain decoding: grant locking, fair rotation, and a bounded hold time.
- Output grants are registered.

Parameters:
- N, 8: number of requesters. Fixed at 8 in this revision; the index is 3 bits.
- IDX_W, 3: index width. Must equal clog2(N).
- MAX_HOLD, 16: maximum consecutive grant cycles while another requester is waiting. 0 disables preemption.
- CNT_W, 5: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when low, no grant is issued or held
- req  in  8  request vector; bit i set means requester i wants the resource
- gnt  out  8  one-hot grant, registered; all zeros when gnt_valid=0
- gnt_idx  out  3  index of the current grantee, registered; holds its last value when idle
- gnt_valid  out  1  a grant is active, registered
- preempt  out  1  one-cycle pulse, registered; high in the first cycle of a grant that was forced by MAX_HOLD

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant clears everything at that same edge. There is no drain.
- ptr (3-bit) is the highest-priority index. Search order is ptr, ptr+1, ... mod 8; wrap from 7 to 0 is required.
- pick(mask) returns the first set bit of (req & mask) in search order, or none.
- IDLE state:
  - If en=1 and req!=0: at the edge, gnt_idx=pick(all), gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency is 1 cycle: gnt is visible in the cycle after req is first sampled high.
- GRANT state, evaluated each edge in this priority order:
  1. en=0: gnt_valid=0, gnt=0, state=IDLE; ptr unchanged.
  2. req[gnt_idx]=0 (release): ptr=gnt_idx+1.
     - Re-arbitrate in the same edge using pick(all except gnt_idx), searched from the new ptr.
     - If a winner exists, it is granted with no bubble and hold_cnt=0.
     - If none, gnt_valid=0 and state=IDLE.
  3. MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another requester is pending: forced rotation.
     - ptr=gnt_idx+1; new grantee = pick(all except gnt_idx); preempt=1 for one cycle; hold_cnt=0.
  4. Otherwise the grant is held and hold_cnt increments. It saturates at MAX_HOLD-1 when no other requester is waiting.
- gnt is always the decode of gnt_idx gated by gnt_valid. It is one-hot or all zeros; no other pattern is ever legal.
- ptr updates only on release or preemption, never on the initial grant from IDLE.
- Simultaneous release and preemption condition: release wins, preempt=0.
- A requester whose req drops in the same cycle its grant appears still receives that one grant cycle. It is then released.
- en toggling while in IDLE has no effect beyond blocking grants.

Decomposition:
- Shared package arb_pkg holds:
  - constants ARB_N=8 and ARB_IDX_W=3
  - state enum {IDLE, GRANT}
  - function onehot8(idx), returning an 8-bit one-hot vector
- One natural sub-module: idx_decode38.
  - 3-to-8 decoder with enable, used to form gnt from gnt_idx and gnt_valid.
  - Reusable elsewhere in the NPC.
- Search logic (rotate req by ptr, priority-encode, un-rotate) stays inside rr_arbiter8.

Test Plan:
- Reset: assert rst with req=8'hFF, en=1 -> next cycle gnt=0, gnt_valid=0, gnt_idx=0. Release rst -> next cycle gnt=8'h01, gnt_idx=0.
- Rotation: en=1, req=8'b1001_0100 held, each grantee drops req for 1 cycle after 3 cycles -> grant order idx 2, 4, 7, 2, with no idle cycle between grants.
- Wrap-around: ptr=7 (after releasing idx 6), req=8'b0000_0011 -> next grant idx 0, then idx 1 after release.
- Preemption with MAX_HOLD=4: req[3] held high, req[5] raised at cycle 1.
  - gnt_idx=3 for exactly 4 cycles, then gnt_idx=5 with preempt=1 for one cycle.
  - With req[5] low, idx 3 holds indefinitely and preempt stays 0.
- Enable drop: grant on idx 6 active, en=0 for 2 cycles -> gnt=0 the next cycle. en=1 -> idx 6 regranted, since ptr is unchanged.
- Invariant check, random req/en for 10k cycles: gnt is one-hot or zero, gnt==onehot8(gnt_idx) whenever gnt_valid=1, and no pending requester waits more than 7*MAX_HOLD+8 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration definitions for the NPC resource arbiters.
//   ARB_N / ARB_IDX_W : requester count and index width
//   arb_state_e       : arbiter sequencing states
//   onehot8()         : 3-bit index to 8-bit one-hot expansion
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/idx_decode38.sv
// 3-to-8 decoder with enable.
//   en_i  : when low the output is all zeros
//   idx_i : index to decode
//   dec_o : one-hot decode of idx_i, or zero
module idx_decode38
  import arb_pkg::*;
(
  input  logic                 en_i,
  input  logic [ARB_IDX_W-1:0] idx_i,
  output logic [ARB_N-1:0]     dec_o
);

  assign dec_o = en_i ? onehot8(idx_i) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant locking and bounded hold.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   en        : global enable; low blocks and drops grants
//   req       : request vector
//   gnt       : one-hot grant (decode of registered gnt_idx/gnt_valid)
//   gnt_idx   : index of current grantee; holds last value when idle
//   gnt_valid : a grant is active
//   preempt   : one-cycle pulse on the first cycle of a forced rotation
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             vld_q, vld_d;
  logic             pre_q, pre_d;

  // Returns {found, index}: rotate so ptr lands at bit 0, take the lowest
  // set bit, then add ptr back (modulo 8 through the index width).
  function automatic logic [IDX_W:0] pick_fn(input logic [N-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    dbl = {r, r} >> p;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return {|rot, IDX_W'(p + off)};
  endfunction

  logic [N-1:0]     other_req;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W:0]   pick_all;
  logic [IDX_W:0]   pick_oth;

  assign other_req = req & ~onehot8(idx_q);
  assign ptr_nxt   = idx_q + 1'b1;
  assign pick_all  = pick_fn(req, ptr_q);
  // The current grantee sits last in order from ptr_nxt, so masking it out
  // is equivalent to searching every other requester from the new pointer.
  assign pick_oth  = pick_fn(other_req, ptr_nxt);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    vld_d   = vld_q;
    pre_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_all[IDX_W]) begin
          idx_d   = pick_all[IDX_W-1:0];
          vld_d   = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!en) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else if (!req[idx_q]) begin
          // Release takes precedence over preemption; hand over without a bubble.
          ptr_d = ptr_nxt;
          if (pick_oth[IDX_W]) begin
            idx_d  = pick_oth[IDX_W-1:0];
            hold_d = '0;
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && (|other_req)) begin
          ptr_d  = ptr_nxt;
          idx_d  = pick_oth[IDX_W-1:0];
          pre_d  = 1'b1;
          hold_d = '0;
        end else if (PREEMPT_EN && (hold_q != HOLD_LAST)) begin
          // Saturates at HOLD_LAST so a late-arriving waiter triggers rotation at once.
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Registered stage: state, pointer, grantee, hold counter, pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
    end
  end

  idx_decode38 u_dec (
    .en_i  (vld_q),
    .idx_i (idx_q),
    .dec_o (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign preempt   = pre_q;

endmodule
